// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage feeding the IF/ID register.
// Holds the PC, reads each 32-bit instruction as four byte reads from the
// byte-wide memory controller (req/ack), and presents a registered
// {pc, inst, valid} to IF/ID. Handles branch redirect and downstream stall.
// Optional feature macro: IF_ICACHE_EN (direct-mapped one-word-per-line
// instruction cache). With the macro undefined every fetch goes to memory.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | one cycle after reset release, no request
// S_FETCH | requesting byte k of the word at r_pc (or probing the cache)
// S_HOLD  | word presented to IF/ID, waiting for it to be consumed
module if_fetch #(
   parameter int          ADDR_W       = 17,
   parameter logic [31:0] RESET_PC     = 32'h0,
   parameter int          ICACHE_LINES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic              branch_flag_i,
   input  logic [31:0]       branch_target_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ack_i,
   input  logic [7:0]        mem_data_i,
   output logic [31:0]       if_pc_o,
   output logic [31:0]       if_inst_o,
   output logic              if_valid_o,
   output logic              stallreq_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   logic [1:0]        r_state;
   logic [31:0]       r_pc;
   logic [1:0]        r_k;
   logic [23:0]       r_bytes;
   logic [31:0]       r_if_pc;
   logic [31:0]       r_if_inst;
   logic              r_if_valid;

   logic              w_in_fetch;
   logic              w_hit;
   logic [31:0]       w_hit_word;
   logic              w_ack;
   logic [ADDR_W-1:0] w_addr;
   logic [31:0]       w_word;
   logic              w_unused;

`ifdef IF_ICACHE_EN
   localparam int IDX_W = $clog2(ICACHE_LINES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   logic [31:0]             r_c_data [ICACHE_LINES];
   logic [TAG_W-1:0]        r_c_tag  [ICACHE_LINES];
   logic [ICACHE_LINES-1:0] r_c_valid;
   logic [IDX_W-1:0]        w_idx;
   logic [TAG_W-1:0]        w_tag;
   logic                    w_fill;

   assign w_idx      = r_pc[IDX_W+1:2];
   assign w_tag      = r_pc[ADDR_W-1:IDX_W+2];
   assign w_hit      = w_in_fetch && (r_k == 2'd0) && r_c_valid[w_idx]
                       && (r_c_tag[w_idx] == w_tag);
   assign w_hit_word = r_c_data[w_idx];
   // A redirect in the same cycle as the last byte abandons the fill.
   assign w_fill     = w_ack && (r_k == 2'd3) && !branch_flag_i;

   // Cache line storage, written only when a memory fetch completes.
   always_ff @(posedge clk) begin
      if (rst && w_fill) begin
         r_c_data[w_idx] <= w_word;
         r_c_tag[w_idx]  <= w_tag;
      end
   end

   // Line valid bits, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_c_valid <= '0;
      end else if (w_fill) begin
         r_c_valid[w_idx] <= 1'b1;
      end
   end

   assign w_unused = ^{stall[5:2], stall[0], branch_target_i[1:0]};
`else
   localparam logic [31:0] P_LINES = ICACHE_LINES;

   assign w_hit      = 1'b0;
   assign w_hit_word = 32'h0;
   assign w_unused   = ^{stall[5:2], stall[0], branch_target_i[1:0], P_LINES};
`endif

   assign w_in_fetch = (r_state == S_FETCH);
   assign w_addr     = r_pc[ADDR_W-1:0] + ADDR_W'(r_k);
   assign w_ack      = mem_ack_i && mem_req_o;
   assign w_word     = {mem_data_i, r_bytes};

   assign mem_req_o  = w_in_fetch && !w_hit;
   assign mem_addr_o = mem_req_o ? w_addr : '0;
   assign stallreq_o = w_in_fetch;
   assign if_pc_o    = r_if_pc;
   assign if_inst_o  = r_if_inst;
   assign if_valid_o = r_if_valid;

   // Fetch sequencing: reset, then redirect, then per-state byte collection.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_k        <= 2'd0;
         r_bytes    <= 24'h0;
         r_if_pc    <= 32'h0;
         r_if_inst  <= 32'h0;
         r_if_valid <= 1'b0;
      end else if (branch_flag_i) begin
         r_pc       <= {branch_target_i[31:2], 2'b00};
         r_k        <= 2'd0;
         r_if_valid <= 1'b0;
         r_state    <= S_FETCH;
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_FETCH;
            S_FETCH: begin
               if (w_hit) begin
                  r_if_inst  <= w_hit_word;
                  r_if_pc    <= r_pc;
                  r_if_valid <= 1'b1;
                  r_state    <= S_HOLD;
               end else if (w_ack) begin
                  case (r_k)
                     2'd0: r_bytes[7:0]   <= mem_data_i;
                     2'd1: r_bytes[15:8]  <= mem_data_i;
                     2'd2: r_bytes[23:16] <= mem_data_i;
                     default: begin
                        r_if_inst  <= w_word;
                        r_if_pc    <= r_pc;
                        r_if_valid <= 1'b1;
                        r_state    <= S_HOLD;
                     end
                  endcase
                  r_k <= r_k + 2'd1;
               end
            end
            S_HOLD: begin
               if (!stall[1]) begin
                  r_pc       <= r_pc + 32'd4;
                  r_k        <= 2'd0;
                  r_if_valid <= 1'b0;
                  r_state    <= S_FETCH;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch (default build, no instruction cache).
// Directed cycle table followed by randomized traffic against a
// transaction-level model of the fetch stream.
module tb_if_fetch;

   localparam logic [31:0] MASK = 32'h1FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [5:0]  stall = '0;
   logic        branch_flag_i = 1'b0;
   logic [31:0] branch_target_i = '0;
   logic        mem_req_o;
   logic [16:0] mem_addr_o;
   logic        mem_ack_i = 1'b0;
   logic [7:0]  mem_data_i = '0;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        if_valid_o;
   logic        stallreq_o;

   int n_vec = 0;
   int n_err = 0;

   if_fetch #(.ADDR_W(17), .RESET_PC(32'h0), .ICACHE_LINES(64)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
      .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
      .if_valid_o(if_valid_o), .stallreq_o(stallreq_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rs, st, br;
      logic [31:0] tgt;
      logic        ack;
      logic [7:0]  dat;
      logic        e_req;
      logic [16:0] e_addr;
      logic        e_val;
      logic [31:0] e_pc, e_inst;
      logic        e_sr;
   } vec_t;

   vec_t tbl[$];

   function automatic void v(input logic rs, input logic st, input logic br,
                             input logic [31:0] tgt, input logic ack, input logic [7:0] dat,
                             input logic e_req, input logic [16:0] e_addr, input logic e_val,
                             input logic [31:0] e_pc, input logic [31:0] e_inst,
                             input logic e_sr);
      vec_t x;
      x.rs = rs; x.st = st; x.br = br; x.tgt = tgt; x.ack = ack; x.dat = dat;
      x.e_req = e_req; x.e_addr = e_addr; x.e_val = e_val;
      x.e_pc = e_pc; x.e_inst = e_inst; x.e_sr = e_sr;
      tbl.push_back(x);
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] byte_at(input logic [31:0] a);
      logic [31:0] t;
      t = (a & MASK) * 32'h9E3779B1;
      return t[23:16] ^ a[7:0];
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] pc);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = byte_at(pc + 32'(i));
      return w;
   endfunction

   logic [31:0] m_pc;
   int          m_k;
   bit          m_idle;
   logic        r_rs, r_st, r_br, r_ack;
   logic [31:0] r_tgt;
   logic        exp_req, exp_val;

   initial begin
      // reset, first fetch of 0x00000013
      v(0,0,0,0,0,8'h00,      0,17'h0,0,32'h0,32'h0,0);
      v(1,0,0,0,0,8'h00,      1,17'h0,0,32'h0,32'h0,1);
      v(1,0,0,0,1,8'h13,      1,17'h1,0,32'h0,32'h0,1);
      v(1,0,0,0,1,8'h00,      1,17'h2,0,32'h0,32'h0,1);
      v(1,0,0,0,1,8'h00,      1,17'h3,0,32'h0,32'h0,1);
      v(1,0,0,0,1,8'h00,      0,17'h0,1,32'h0,32'h13,0);
      // stall in HOLD (stray ack ignored), then release
      v(1,1,0,0,0,8'h00,      0,17'h0,1,32'h0,32'h13,0);
      v(1,1,0,0,1,8'hff,      0,17'h0,1,32'h0,32'h13,0);
      v(1,1,0,0,0,8'h00,      0,17'h0,1,32'h0,32'h13,0);
      v(1,0,0,0,0,8'h00,      1,17'h4,0,32'h0,32'h13,1);
      v(1,0,0,0,1,8'h01,      1,17'h5,0,32'h0,32'h13,1);
      v(1,0,0,0,1,8'h02,      1,17'h6,0,32'h0,32'h13,1);
      v(1,0,0,0,1,8'h03,      1,17'h7,0,32'h0,32'h13,1);
      v(1,0,0,0,1,8'h04,      0,17'h0,1,32'h4,32'h04030201,0);
      // pc=8: two bytes, then branch to 0x103 with simultaneous ack
      v(1,0,0,0,0,8'h00,      1,17'h8,0,32'h4,32'h04030201,1);
      v(1,0,0,0,1,8'haa,      1,17'h9,0,32'h4,32'h04030201,1);
      v(1,0,0,0,1,8'hbb,      1,17'ha,0,32'h4,32'h04030201,1);
      v(1,0,1,32'h103,1,8'hcc,1,17'h100,0,32'h4,32'h04030201,1);
      v(1,0,0,0,1,8'h11,      1,17'h101,0,32'h4,32'h04030201,1);
      v(1,0,0,0,1,8'h22,      1,17'h102,0,32'h4,32'h04030201,1);
      v(1,0,0,0,1,8'h33,      1,17'h103,0,32'h4,32'h04030201,1);
      v(1,0,0,0,1,8'h44,      0,17'h0,1,32'h100,32'h44332211,0);
      // reset mid-fetch at k=2 with an ack in the reset cycle
      v(1,0,0,0,0,8'h00,      1,17'h104,0,32'h100,32'h44332211,1);
      v(1,0,0,0,1,8'h55,      1,17'h105,0,32'h100,32'h44332211,1);
      v(1,0,0,0,1,8'h66,      1,17'h106,0,32'h100,32'h44332211,1);
      v(0,0,0,0,1,8'h77,      0,17'h0,0,32'h0,32'h0,0);
      v(1,0,0,0,0,8'h00,      1,17'h0,0,32'h0,32'h0,1);
      // address wrap at the top of the 17-bit space
      v(1,0,1,32'h1fffc,0,8'h00, 1,17'h1fffc,0,32'h0,32'h0,1);
      v(1,0,0,0,1,8'h01,      1,17'h1fffd,0,32'h0,32'h0,1);
      v(1,0,0,0,1,8'h02,      1,17'h1fffe,0,32'h0,32'h0,1);
      v(1,0,0,0,1,8'h03,      1,17'h1ffff,0,32'h0,32'h0,1);
      v(1,0,0,0,1,8'h04,      0,17'h0,1,32'h1fffc,32'h04030201,0);
      v(1,0,0,0,0,8'h00,      1,17'h0,0,32'h1fffc,32'h04030201,1);
      v(1,0,0,0,1,8'ha0,      1,17'h1,0,32'h1fffc,32'h04030201,1);
      v(1,0,0,0,1,8'ha1,      1,17'h2,0,32'h1fffc,32'h04030201,1);
      v(1,0,0,0,1,8'ha2,      1,17'h3,0,32'h1fffc,32'h04030201,1);
      v(1,0,0,0,1,8'ha3,      0,17'h0,1,32'h20000,32'ha3a2a1a0,0);
      // branch beats stall in HOLD
      v(1,1,1,32'h43,0,8'h00, 1,17'h40,0,32'h20000,32'ha3a2a1a0,1);
      // ack during IDLE ignored
      v(0,0,0,0,0,8'h00,      0,17'h0,0,32'h0,32'h0,0);
      v(1,0,0,0,1,8'hff,      1,17'h0,0,32'h0,32'h0,1);
      v(1,0,0,0,1,8'h10,      1,17'h1,0,32'h0,32'h0,1);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst = tbl[i].rs;
         stall = {4'b0, tbl[i].st, 1'b0};
         branch_flag_i = tbl[i].br;
         branch_target_i = tbl[i].tgt;
         mem_ack_i = tbl[i].ack;
         mem_data_i = tbl[i].dat;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i),
               {44'h0, mem_req_o, mem_addr_o, if_valid_o, if_pc_o, if_inst_o, stallreq_o},
               {44'h0, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_val, tbl[i].e_pc,
                tbl[i].e_inst, tbl[i].e_sr});
      end

      // randomized phase
      @(negedge clk);
      rst = 1'b0; stall = '0; branch_flag_i = 1'b0; mem_ack_i = 1'b0;
      @(posedge clk);
      m_idle = 1'b1; m_pc = 32'h0; m_k = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         exp_req = !m_idle && (m_k < 4);
         exp_val = !m_idle && (m_k == 4);
         check("rnd_req", 128'(mem_req_o), 128'(exp_req));
         check("rnd_stallreq", 128'(stallreq_o), 128'(exp_req));
         check("rnd_valid", 128'(if_valid_o), 128'(exp_val));
         if (exp_req)
            check("rnd_addr", 128'(mem_addr_o), 128'((m_pc + 32'(m_k)) & MASK));
         if (exp_val) begin
            check("rnd_pc", 128'(if_pc_o), 128'(m_pc));
            check("rnd_inst", 128'(if_inst_o), 128'(word_at(m_pc)));
         end
         if (m_idle)
            check("rnd_idle_out", {mem_addr_o, if_pc_o, if_inst_o}, 128'h0);

         r_rs  = ($urandom % 250) != 0;
         r_st  = ($urandom % 3) == 0;
         r_br  = ($urandom % 40) == 0;
         r_tgt = (($urandom % 4) == 0) ? (32'h1fff0 + ($urandom % 16)) : $urandom;
         r_ack = mem_req_o ? (($urandom % 3) != 0) : (($urandom % 6) == 0);
         rst = r_rs;
         stall = 6'($urandom);
         stall[1] = r_st;
         branch_flag_i = r_br;
         branch_target_i = r_tgt;
         mem_ack_i = r_ack;
         mem_data_i = byte_at({15'h0, mem_addr_o});

         if (!r_rs) begin
            m_idle = 1'b1; m_pc = 32'h0; m_k = 0;
         end else if (r_br) begin
            m_pc = r_tgt & ~32'h3; m_k = 0; m_idle = 1'b0;
         end else if (m_idle) begin
            m_idle = 1'b0;
         end else if (m_k < 4) begin
            if (r_ack) m_k++;
         end else if (!r_st) begin
            m_pc = m_pc + 32'd4; m_k = 0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
